// File: rtl/sync_async_bridge_m.sv
// sync_async_bridge_m: clocked valid/ready stream into a DEPTH-entry FIFO,
// emptied one word at a time onto a 4-phase bundled-data req/ack channel.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   in_data/in_valid   upstream write stream; in_ready is the accept qualifier
//   data_out           bundled data, stable from SETUP until ack falls
//   right_req_out      4-phase request; right_ack_in is the async acknowledge
//   count              FIFO occupancy
//   busy               handshake FSM not idle
//   err                sticky handshake-phase timeout flag
module sync_async_bridge_m #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               data_out,
  output logic                           right_req_out,
  input  logic                           right_ack_in,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);
  localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [TW-1:0]     phase_cnt_q, phase_cnt_d;
  logic              ack_s1_q, ack_s_q;
  logic              empty, full, pop, push, phase_tick;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNTW'(DEPTH));

  // A pop frees a slot this cycle, so a full FIFO can still take a word.
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  // Handshake FSM: next state, pop strobe, data/req/timeout updates.
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    req_d       = req_q;
    err_d       = err_q;
    phase_cnt_d = phase_cnt_q;
    pop         = 1'b0;
    phase_tick  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          data_out_d = mem_q[rd_ptr_q];
          state_d    = SETUP;
        end
      end
      SETUP: begin
        req_d       = 1'b1;
        phase_cnt_d = '0;
        state_d     = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s_q) begin
          req_d       = 1'b0;
          phase_cnt_d = '0;
          state_d     = REQ_LO;
        end else begin
          phase_tick = 1'b1;
        end
      end
      REQ_LO: begin
        if (!ack_s_q) begin
          if (!empty) begin
            pop        = 1'b1;
            data_out_d = mem_q[rd_ptr_q];
            state_d    = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_tick = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturating phase counter; err latches when a phase reaches TIMEOUT cycles.
    if (phase_tick) begin
      if (phase_cnt_q != TW'(TIMEOUT)) begin
        phase_cnt_d = phase_cnt_q + TW'(1);
      end
      if (TO_EN && (phase_cnt_q + TW'(1) == TW'(TIMEOUT))) begin
        err_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, no reset needed: only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      phase_cnt_q <= '0;
      ack_s1_q    <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      phase_cnt_q <= phase_cnt_d;
      ack_s1_q    <= right_ack_in;
      ack_s_q     <= ack_s1_q;
    end
  end

  assign data_out      = data_out_q;
  assign right_req_out = req_q;
  assign count         = count_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_sync_async_bridge_m.sv
// Bench for sync_async_bridge_m: reset/latency vector table, fill and
// simultaneous push/pop sequence, random stream with an order scoreboard,
// and handshake timeout.
module tb_sync_async_bridge_m;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNTW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             right_req_out;
  logic             right_ack_in;
  logic [CNTW-1:0]  count;
  logic             busy;
  logic             err;

  sync_async_bridge_m #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .right_req_out(right_req_out),
    .right_ack_in(right_ack_in), .count(count), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acknowledge model: either driven by hand or following req after a delay.
  logic man_ack  = 1'b0;
  logic auto_val = 1'b0;
  bit   auto_ack = 1'b0;
  bit   rand_dly = 1'b0;
  int   ack_delay = 5;
  assign right_ack_in = auto_ack ? auto_val : man_ack;

  initial forever begin
    @(right_req_out);
    if (auto_ack) begin
      #(ack_delay);
      auto_val = right_req_out;
      if (rand_dly) ack_delay = $urandom_range(1, 30);
    end
  end

  // Reference model: words leave in acceptance order; each req rise must
  // present the oldest outstanding word, and data may not move mid-handshake.
  logic [WIDTH-1:0] sb [$];
  bit               mon_en = 1'b0;
  int               n_rises = 0;
  initial begin
    logic             pv, prev_req, prev_ack;
    logic [WIDTH-1:0] pd, prev_data, exp_w;
    prev_req = 1'b0; prev_ack = 1'b0; prev_data = '0;
    forever begin
      @(posedge clk);
      pv = in_valid && in_ready && reset;
      pd = in_data;
      #1;
      if (!reset) sb.delete();
      if (mon_en) begin
        if (pv) sb.push_back(pd);
        if (prev_req || prev_ack) check("data_stable", 32'(data_out), 32'(prev_data));
        if (right_req_out && !prev_req) begin
          n_rises++;
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL order: req rose with data %0h but no word outstanding", data_out);
          end else begin
            exp_w = sb.pop_front();
            check("order", 32'(data_out), 32'(exp_w));
          end
        end
      end
      prev_req = right_req_out; prev_ack = right_ack_in; prev_data = data_out;
    end
  end

  typedef struct {
    logic             rst_n;
    logic             v;
    logic [WIDTH-1:0] d;
    logic             ack;
    logic             ex_req;
    logic [WIDTH-1:0] ex_data;
    logic [CNTW-1:0]  ex_cnt;
    logic             ex_busy;
    logic             ex_rdy;
  } vec_t;

  vec_t tbl [12];

  task automatic push_word(input logic [WIDTH-1:0] w);
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = w;
    for (int t = 0; t < 400 && !acc; t++) begin
      #1 acc = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; man_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(posedge clk); #1;
      done = !busy && (count == '0);
    end
    check({name, "_drained"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic lvl, input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk); #1;
      seen = (right_req_out == lvl);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;

    // Reset hold then single-word handshake with hand-driven ack.
    tbl[0]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst_n; in_valid = tbl[i].v; in_data = tbl[i].d; man_ack = tbl[i].ack;
      @(posedge clk); #1;
      check($sformatf("vec%0d_req", i),   32'(right_req_out), 32'(tbl[i].ex_req));
      check($sformatf("vec%0d_data", i),  32'(data_out),      32'(tbl[i].ex_data));
      check($sformatf("vec%0d_count", i), 32'(count),         32'(tbl[i].ex_cnt));
      check($sformatf("vec%0d_busy", i),  32'(busy),          32'(tbl[i].ex_busy));
      check($sformatf("vec%0d_ready", i), 32'(in_ready),      32'(tbl[i].ex_rdy));
      check($sformatf("vec%0d_err", i),   32'(err),           32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Fill behind a stalled handshake, then push into a full FIFO during a pop.
    mon_en = 1'b1;
    push_word(8'h10);
    wait_req(1'b1, "fill_req_rise");
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push_word(WIDTH'(8'h10 + i));
    in_valid = 1'b1; in_data = 8'h15;
    #1;
    check("fill_ready_low", 32'(in_ready), 32'd0);
    check("fill_count",     32'(count),    32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("fill_held_count", 32'(count),    32'd4);
    check("fill_held_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    man_ack = 1'b1;
    wait_req(1'b0, "fill_req_fall");
    @(negedge clk);
    man_ack = 1'b0;
    begin
      bit hit = 1'b0;
      for (int t = 0; t < 10 && !hit; t++) begin
        #1 hit = in_ready;
        @(posedge clk); #1;
        if (hit) begin
          check("simul_count", 32'(count),    32'd4);
          check("simul_ready", 32'(in_ready), 32'd0);
          check("simul_data",  32'(data_out), 32'h11);
        end
        @(negedge clk);
      end
      check("simul_seen", 32'(hit), 32'd1);
    end
    in_valid = 1'b0;
    ack_delay = 5; auto_val = 1'b0; auto_ack = 1'b1;
    wait_drain("fill");
    check("fill_all_out", 32'(sb.size()), 32'd0);

    // Random stream with random ack delays; wraps the pointers several times.
    mon_en = 1'b0;
    do_reset();
    check("rst_err_clear", 32'(err), 32'd0);
    mon_en = 1'b1; n_rises = 0; rand_dly = 1'b1; ack_delay = 7;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_word(WIDTH'($urandom));
    end
    wait_drain("stream");
    check("stream_all_out", 32'(sb.size()), 32'd0);
    check("stream_rises",   32'(n_rises),   32'd16);
    check("stream_no_err",  32'(err),       32'd0);

    // Timeout: ack never comes; err exactly TIMEOUT cycles after REQ_HI entry.
    mon_en = 1'b0; auto_ack = 1'b0; rand_dly = 1'b0;
    do_reset();
    push_word(8'h5A);
    wait_req(1'b1, "to_req_rise");
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      @(posedge clk); #1;
      if (k == int'(TIMEOUT) - 1) check("to_err_early", 32'(err), 32'd0);
    end
    check("to_err_set",  32'(err),           32'd1);
    check("to_req_held", 32'(right_req_out), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("to_rst_req",  32'(right_req_out), 32'd0);
    check("to_rst_err",  32'(err),           32'd0);
    check("to_rst_busy", 32'(busy),          32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("to_rst_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
